// File: rtl/tmr_fault_manager_if.sv
// Control/status bundle between the TMR supervisor and its host.
// The host drives commands and voter flags; the supervisor drives enables and status.
interface tmr_fault_manager_if #(
    parameter int CNT_W = 4
);
    logic                 start;
    logic                 stop;
    logic                 clear;
    logic [2:0]           fault_vec;
    logic                 no_majority;
    logic                 run_en;
    logic [2:0]           resync;
    logic [2:0]           replica_ok;
    logic [3*CNT_W-1:0]   err_cnt;
    logic [2:0]           state;
    logic                 alarm;

    modport master (
        output start, stop, clear, fault_vec, no_majority,
        input  run_en, resync, replica_ok, err_cnt, state, alarm
    );

    modport slave (
        input  start, stop, clear, fault_vec, no_majority,
        output run_en, resync, replica_ok, err_cnt, state, alarm
    );
endinterface

// File: rtl/tmr_fault_manager.sv
// Supervisor for a triple-redundant counter: gates counting, sequences resyncs,
// keeps leaky per-replica error history and retires chronic offenders.
module tmr_fault_manager #(
    parameter int CNT_W       = 4,
    parameter int MAX_ERR     = 3,
    parameter int RESYNC_CYC  = 2,
    parameter int LEAK_PERIOD = 64
) (
    input logic               clk,
    input logic               rst,
    tmr_fault_manager_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RUN      = 3'd1,
        RESYNC   = 3'd2,
        DEGRADED = 3'd3,
        HALT     = 3'd4
    } state_t;

    localparam int LW = (LEAK_PERIOD > 1) ? $clog2(LEAK_PERIOD) : 1;

    state_t                  st;
    logic                    run_en_q;
    logic [2:0]              resync_q;
    logic [2:0]              ok_q;
    logic [2:0][CNT_W-1:0]   err_q;
    logic                    alarm_q;
    logic [LW-1:0]           leak_q;
    logic [3:0]              hold_q;

    logic [2:0]              mf;
    logic [2:0]              keep;
    logic [1:0]              n_keep;
    logic [2:0][CNT_W-1:0]   err_inc;
    logic [2:0][CNT_W-1:0]   err_dec;

    // Retired replicas never count as faulty, so their flags are masked out.
    always_comb begin
        mf = bus.fault_vec & ok_q;
        for (int i = 0; i < 3; i++) begin
            err_inc[i] = (mf[i] && (err_q[i] != '1)) ?
                         err_q[i] + CNT_W'(1) : err_q[i];
            err_dec[i] = (err_q[i] != '0) ?
                         err_q[i] - CNT_W'(1) : err_q[i];
            keep[i]    = ok_q[i] && (int'(err_q[i]) < MAX_ERR);
        end
        n_keep = 2'(keep[0]) + 2'(keep[1]) + 2'(keep[2]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st       <= IDLE;
            run_en_q <= 1'b0;
            resync_q <= 3'b000;
            ok_q     <= 3'b111;
            err_q    <= '0;
            alarm_q  <= 1'b0;
            leak_q   <= '0;
            hold_q   <= '0;
        end else begin
            unique case (st)
                IDLE: begin
                    if (bus.start) begin
                        st       <= RUN;
                        run_en_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (bus.no_majority) begin
                        st       <= HALT;
                        run_en_q <= 1'b0;
                        alarm_q  <= 1'b1;
                        leak_q   <= '0;
                    end else if (|mf) begin
                        st       <= RESYNC;
                        run_en_q <= 1'b0;
                        resync_q <= mf;
                        err_q    <= err_inc;
                        hold_q   <= 4'(RESYNC_CYC - 1);
                        leak_q   <= '0;
                    end else if (bus.stop) begin
                        st       <= IDLE;
                        run_en_q <= 1'b0;
                        leak_q   <= '0;
                    end else if (leak_q == LW'(LEAK_PERIOD - 1)) begin
                        err_q    <= err_dec;
                        leak_q   <= '0;
                    end else begin
                        leak_q   <= leak_q + LW'(1);
                    end
                end
                RESYNC: begin
                    if (hold_q != 4'd0) begin
                        hold_q <= hold_q - 4'd1;
                    end else begin
                        resync_q <= 3'b000;
                        ok_q     <= keep;
                        if (n_keep == 2'd3) begin
                            st       <= RUN;
                            run_en_q <= 1'b1;
                        end else if (n_keep == 2'd2) begin
                            st       <= DEGRADED;
                            run_en_q <= 1'b1;
                        end else begin
                            st       <= HALT;
                            alarm_q  <= 1'b1;
                        end
                    end
                end
                DEGRADED: begin
                    // Two voters cannot settle a disagreement.
                    if ((|mf) || bus.no_majority) begin
                        st       <= HALT;
                        run_en_q <= 1'b0;
                        alarm_q  <= 1'b1;
                    end else if (bus.stop) begin
                        st       <= IDLE;
                        run_en_q <= 1'b0;
                    end
                end
                HALT: begin
                    if (bus.clear) begin
                        st      <= IDLE;
                        alarm_q <= 1'b0;
                        err_q   <= '0;
                        ok_q    <= 3'b111;
                    end
                end
                default: begin
                    st       <= IDLE;
                    run_en_q <= 1'b0;
                    resync_q <= 3'b000;
                end
            endcase
        end
    end

    assign bus.state      = st;
    assign bus.run_en     = run_en_q;
    assign bus.resync     = resync_q;
    assign bus.replica_ok = ok_q;
    assign bus.err_cnt    = err_q;
    assign bus.alarm      = alarm_q;
endmodule
